// File: rtl/vram_port_arbiter_if.sv
// Bundle of display-read, sprite-write, clear-control and BRAM-port signals for vram_port_arbiter.
// master = the users driving requests, slave = the arbiter itself.
interface vram_port_arbiter_if #(
   parameter int ADDR_W = 17,
   parameter int DATA_W = 12
);
   logic              disp_req;
   logic [ADDR_W-1:0] disp_addr;
   logic              rd_valid;

   logic              wr_valid;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ready;

   logic              clr_start;
   logic [DATA_W-1:0] clr_color;
   logic              clr_busy;
   logic              clr_done;

   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_din;

   modport master (
      output disp_req, disp_addr, wr_valid, wr_addr, wr_data, clr_start, clr_color,
      input  rd_valid, wr_ready, clr_busy, clr_done, mem_addr, mem_we, mem_din
   );

   modport slave (
      input  disp_req, disp_addr, wr_valid, wr_addr, wr_data, clr_start, clr_color,
      output rd_valid, wr_ready, clr_busy, clr_done, mem_addr, mem_we, mem_din
   );
endinterface

// File: rtl/vram_port_arbiter.sv
// Single-port frame-buffer arbiter: display reads always win, then the clear sweep, then buffered writes.
// Optional macro ARB_STATS_EN adds the saturating wr_stall_cnt output.
module vram_port_arbiter #(
   parameter int ADDR_W     = 17,
   parameter int DATA_W     = 12,
   parameter int FIFO_DEPTH = 8,
   parameter int RD_LAT     = 1,
   parameter int MEM_WORDS  = 76800
) (
   input  logic                clk,
   input  logic                rst,
   vram_port_arbiter_if.slave  bus
`ifdef ARB_STATS_EN
   ,
   output logic [15:0]         wr_stall_cnt
`endif
);
   localparam int                PTR_W      = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0]    FULL_COUNT = (PTR_W+1)'(FIFO_DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(MEM_WORDS - 1);

   typedef enum logic {IDLE, CLEAR} state_t;
   typedef enum logic [1:0] {GRANT_NONE, GRANT_DISP, GRANT_CLEAR, GRANT_FIFO} grant_t;

   state_t            state_q, state_d;
   grant_t            grant;
   logic [ADDR_W-1:0] clr_ptr;
   logic [DATA_W-1:0] clr_color_q;
   logic              clr_done_q;
   logic              clr_last;

   logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
   logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [PTR_W:0]    count;
   logic              push, pop;

   logic [ADDR_W-1:0] mem_addr_q;
   logic              mem_we_q;
   logic [DATA_W-1:0] mem_din_q;
   logic [RD_LAT:0]   rd_pipe;

   // NOTE: every variable gets a default at the top of always_comb, so no path infers a latch.
   always_comb begin
      grant = GRANT_NONE;
      if (bus.disp_req)          grant = GRANT_DISP;
      else if (state_q == CLEAR) grant = GRANT_CLEAR;
      else if (count != '0)      grant = GRANT_FIFO;
   end

   assign bus.wr_ready = (count != FULL_COUNT);
   assign push         = bus.wr_valid & bus.wr_ready;
   assign pop          = (grant == GRANT_FIFO);
   assign clr_last     = (grant == GRANT_CLEAR) && (clr_ptr == LAST_ADDR);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.clr_start) state_d = CLEAR;
         CLEAR:   if (clr_last)      state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         clr_ptr     <= '0;
         clr_color_q <= '0;
         clr_done_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_done_q <= clr_last;
         if (state_q == IDLE && bus.clr_start) begin
            clr_ptr     <= '0;
            clr_color_q <= bus.clr_color;
         end else if (grant == GRANT_CLEAR) begin
            clr_ptr <= clr_ptr + 1'b1;
         end
      end
   end

   // Memory port: when nobody is granted the address is held and only the write enable drops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_addr_q <= '0;
         mem_we_q   <= 1'b0;
         mem_din_q  <= '0;
      end else begin
         case (grant)
            GRANT_DISP: begin
               mem_addr_q <= bus.disp_addr;
               mem_we_q   <= 1'b0;
            end
            GRANT_CLEAR: begin
               mem_addr_q <= clr_ptr;
               mem_din_q  <= clr_color_q;
               mem_we_q   <= 1'b1;
            end
            GRANT_FIFO: begin
               mem_addr_q <= fifo_addr[rd_ptr];
               mem_din_q  <= fifo_data[rd_ptr];
               mem_we_q   <= 1'b1;
            end
            default: mem_we_q <= 1'b0;
         endcase
      end
   end

   // NOTE: FIFO storage is not reset; count and pointers make stale entries unreachable.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr] <= bus.wr_addr;
         fifo_data[wr_ptr] <= bus.wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // rd_valid trails disp_req by the address register plus the BRAM read latency.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rd_pipe <= '0;
      else     rd_pipe <= (rd_pipe << 1) | (RD_LAT+1)'(bus.disp_req);
   end

`ifdef ARB_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         wr_stall_cnt <= '0;
      else if (bus.wr_valid && !bus.wr_ready && wr_stall_cnt != 16'hFFFF)
         wr_stall_cnt <= wr_stall_cnt + 16'd1;
   end
`endif

   assign bus.mem_addr = mem_addr_q;
   assign bus.mem_we   = mem_we_q;
   assign bus.mem_din  = mem_din_q;
   assign bus.rd_valid = rd_pipe[RD_LAT];
   assign bus.clr_busy = (state_q == CLEAR);
   assign bus.clr_done = clr_done_q;
endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed self-checking bench for vram_port_arbiter: display priority, FIFO fill/order, clear sweep, reset abort.
// Build with ARB_STATS_EN defined to also check wr_stall_cnt.
`timescale 1ns/1ps
module tb_vram_port_arbiter;
   localparam int ADDR_W    = 17;
   localparam int DATA_W    = 12;
   localparam int MEM_WORDS = 76800;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   vram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
`ifdef ARB_STATS_EN
   logic [15:0] wr_stall_cnt;
`endif

   vram_port_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(8), .RD_LAT(1), .MEM_WORDS(MEM_WORDS)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
`ifdef ARB_STATS_EN
      ,
      .wr_stall_cnt(wr_stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Inputs change at the falling edge; outputs are sampled at the falling edge after a rising edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int  exp_ptr, bad, done_cnt, disp_left, we_cnt;
      bit  pushed, disp_done, restarted, disp_now;

      rst           = 1'b1;
      bus.disp_req  = 1'b0;
      bus.disp_addr = '0;
      bus.wr_valid  = 1'b0;
      bus.wr_addr   = '0;
      bus.wr_data   = '0;
      bus.clr_start = 1'b0;
      bus.clr_color = '0;
      @(negedge clk);
      @(negedge clk);
      check("rst_mem_addr", bus.mem_addr, 0);
      check("rst_mem_we",   bus.mem_we,   0);
      check("rst_mem_din",  bus.mem_din,  0);
      check("rst_rd_valid", bus.rd_valid, 0);
      check("rst_clr_busy", bus.clr_busy, 0);
      check("rst_clr_done", bus.clr_done, 0);
      check("rst_wr_ready", bus.wr_ready, 1);
`ifdef ARB_STATS_EN
      check("rst_stall_cnt", wr_stall_cnt, 0);
`endif
      rst = 1'b0;
      @(negedge clk);

      // Display read: address registered one cycle later, rd_valid one cycle after that.
      bus.disp_req  = 1'b1;
      bus.disp_addr = 17'h00100;
      tick();
      check("t1_mem_addr", bus.mem_addr, 17'h00100);
      check("t1_mem_we",   bus.mem_we,   0);
      check("t1_rd_valid_early", bus.rd_valid, 0);
      bus.disp_req = 1'b0;
      tick();
      check("t1_rd_valid", bus.rd_valid, 1);
      tick();
      check("t1_rd_valid_end", bus.rd_valid, 0);

      // A buffered write waits behind display reads and commits on the first free slot.
      bus.disp_req  = 1'b1;
      bus.disp_addr = 17'h00010;
      bus.wr_valid  = 1'b1;
      bus.wr_addr   = 17'h00050;
      bus.wr_data   = 12'hABC;
      check("t2_wr_ready", bus.wr_ready, 1);
      tick();
      bus.wr_valid = 1'b0;
      check("t2_we_blocked0", bus.mem_we, 0);
      tick();
      check("t2_we_blocked1", bus.mem_we, 0);
      bus.disp_req = 1'b0;
      tick();
      check("t2_mem_we",   bus.mem_we,   1);
      check("t2_mem_addr", bus.mem_addr, 17'h00050);
      check("t2_mem_din",  bus.mem_din,  12'hABC);
      tick();
      check("t2_we_idle",   bus.mem_we,   0);
      check("t2_addr_hold", bus.mem_addr, 17'h00050);

      // Fill the FIFO under continuous display reads; the 9th word must stall, not drop.
      bus.disp_req = 1'b1;
      for (int i = 0; i < 9; i++) begin
         bus.wr_valid = 1'b1;
         bus.wr_addr  = 17'(200 + i);
         bus.wr_data  = 12'(i + 1);
         if (i < 8) begin
            check($sformatf("t3_ready_%0d", i), bus.wr_ready, 1);
            tick();
         end else begin
            check("t3_full", bus.wr_ready, 0);
         end
      end
      for (int s = 1; s <= 3; s++) begin
         tick();
         check($sformatf("t3_full_hold_%0d", s), bus.wr_ready, 0);
         check($sformatf("t3_we_hold_%0d", s), bus.mem_we, 0);
`ifdef ARB_STATS_EN
         check($sformatf("t3_stall_%0d", s), wr_stall_cnt, 16'(s));
`endif
      end
      bus.disp_req = 1'b0;
      tick();
      check("t3_pop0_we",   bus.mem_we,   1);
      check("t3_pop0_addr", bus.mem_addr, 200);
      check("t3_pop0_din",  bus.mem_din,  1);
`ifdef ARB_STATS_EN
      check("t3_stall_4", wr_stall_cnt, 16'd4);
`endif
      check("t3_ready_after_pop", bus.wr_ready, 1);
      tick();
      bus.wr_valid = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         if (k > 1) tick();
         check($sformatf("t3_order_addr_%0d", k), bus.mem_addr, 32'(200 + k));
         check($sformatf("t3_order_din_%0d", k),  bus.mem_din,  32'(k + 1));
      end
      tick();
      check("t3_drained_we", bus.mem_we, 0);
`ifdef ARB_STATS_EN
      check("t3_stall_final", wr_stall_cnt, 16'd4);
`endif

      // Full clear sweep with a mid-sweep FIFO write, a display burst and an ignored restart.
      bus.clr_start = 1'b1;
      bus.clr_color = 12'h3C7;
      tick();
      bus.clr_start = 1'b0;
      bus.clr_color = 12'h000;
      check("t4_busy", bus.clr_busy, 1);
      check("t4_first_we", bus.mem_we, 0);
      exp_ptr = 0; bad = 0; done_cnt = 0; disp_left = 0;
      pushed = 0; disp_done = 0; restarted = 0;
      for (int cyc = 0; cyc < 80000 && exp_ptr < MEM_WORDS; cyc++) begin
         bus.wr_valid  = 1'b0;
         bus.clr_start = 1'b0;
         if (exp_ptr == 200 && !pushed) begin
            bus.wr_valid = 1'b1;
            bus.wr_addr  = 17'h00777;
            bus.wr_data  = 12'hDEF;
            pushed = 1;
         end
         if (exp_ptr == 300 && !disp_done) begin
            disp_left = 2;
            disp_done = 1;
         end
         disp_now      = (disp_left != 0);
         bus.disp_req  = disp_now;
         bus.disp_addr = 17'h00042;
         if (disp_now) disp_left--;
         if (exp_ptr == 500 && !restarted) begin
            bus.clr_start = 1'b1;
            bus.clr_color = 12'h111;
            restarted = 1;
         end
         tick();
         if (bus.clr_done === 1'b1) done_cnt++;
         if (disp_now) begin
            if (bus.mem_we !== 1'b0 || bus.mem_addr !== 17'h00042) bad++;
         end else if (bus.mem_we === 1'b1 && bus.mem_addr == 17'(exp_ptr) && bus.mem_din == 12'h3C7) begin
            exp_ptr++;
         end else begin
            bad++;
         end
         if (exp_ptr < MEM_WORDS && bus.clr_busy !== 1'b1) bad++;
      end
      bus.wr_valid  = 1'b0;
      bus.clr_start = 1'b0;
      bus.disp_req  = 1'b0;
      check("t4_sweep_count", exp_ptr, MEM_WORDS);
      check("t4_sweep_bad",   bad,     0);
      check("t4_last_addr",   bus.mem_addr, MEM_WORDS - 1);
      check("t4_done_pulse",  bus.clr_done, 1);
      check("t4_busy_low",    bus.clr_busy, 0);
      tick();
      check("t4_fifo_we",   bus.mem_we,   1);
      check("t4_fifo_addr", bus.mem_addr, 17'h00777);
      check("t4_fifo_din",  bus.mem_din,  12'hDEF);
      check("t4_done_drop", bus.clr_done, 0);
      for (int w = 0; w < 5; w++) begin
         tick();
         if (bus.clr_done === 1'b1) done_cnt++;
      end
      check("t4_after_we", bus.mem_we, 0);
      check("t6_single_done", done_cnt, 1);

      // Reset during a clear: sweep aborts and the queued FIFO word is discarded.
      bus.clr_start = 1'b1;
      bus.clr_color = 12'h000;
      tick();
      bus.clr_start = 1'b0;
      exp_ptr = 0; bad = 0; pushed = 0;
      for (int cyc = 0; cyc < 2000 && exp_ptr < 1000; cyc++) begin
         bus.wr_valid = 1'b0;
         if (exp_ptr == 10 && !pushed) begin
            bus.wr_valid = 1'b1;
            bus.wr_addr  = 17'h00999;
            bus.wr_data  = 12'h999;
            pushed = 1;
         end
         tick();
         if (bus.mem_we === 1'b1 && bus.mem_addr == 17'(exp_ptr) && bus.mem_din == 12'h000) exp_ptr++;
         else bad++;
      end
      bus.wr_valid = 1'b0;
      check("t5_progress", exp_ptr, 1000);
      check("t5_bad",      bad,     0);
      rst = 1'b1;
      #1;
      check("t5_rst_we",    bus.mem_we,   0);
      check("t5_rst_addr",  bus.mem_addr, 0);
      check("t5_rst_busy",  bus.clr_busy, 0);
      check("t5_rst_ready", bus.wr_ready, 1);
`ifdef ARB_STATS_EN
      check("t5_rst_stall", wr_stall_cnt, 0);
`endif
      @(negedge clk);
      rst = 1'b0;
      we_cnt = 0;
      for (int w = 0; w < 20; w++) begin
         tick();
         if (bus.mem_we !== 1'b0) we_cnt++;
      end
      check("t5_no_writes", we_cnt, 0);
      check("t5_busy_after", bus.clr_busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
